button_event_arbiter: RTL and testbench

Collects falling-edge (press) events from NUM_BTN debounced, active-low pushbuttons and queues one pending flag per button. Events are delivered one at a time to the game logic, such as paddle control or serve/pause, over a valid/ready handshake. A round-robin arbiter shares the single event channel fairly between buttons. Sits between the debouncers and the Pong game-state controller.

---
 rtl/button_event_arbiter_pkg.sv | 31 +++
 rtl/button_event_arbiter_if.sv | 9 +
 rtl/button_event_arbiter_edge.sv | 46 ++++
 rtl/button_event_arbiter.sv | 83 ++++++++
 tb/tb_button_event_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/button_event_arbiter_pkg.sv
// Shared constants and helpers for the button event arbiter.
// Holds the FSM encoding, the ID width helper and the round-robin pick function.
package button_event_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  localparam int MAX_BTN = 8;

  function automatic int clog2_id(input int n);
    for (int w = 0; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

  // First set request found scanning upward from last+1, wrapping modulo n.
  function automatic logic [2:0] rr_pick(input logic [MAX_BTN-1:0] req,
                                         input logic [2:0] last,
                                         input int n);
    logic [2:0] r_sel;
    logic [2:0] idx;
    r_sel = last;
    for (int k = n; k >= 1; k--) begin
      idx = 3'((int'(last) + k) % n);
      if (req[idx]) r_sel = idx;
    end
    return r_sel;
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event channel between the arbiter (master) and the game-state controller (slave).
interface button_event_arbiter_if #(parameter int ID_W = 2);
  logic            EventValid;
  logic            EventReady;
  logic [ID_W-1:0] EventId;

  modport master (output EventValid, output EventId, input EventReady);
  modport slave  (input EventValid, input EventId, output EventReady);
endinterface

// File: rtl/button_event_arbiter_edge.sv
// Per-button press detector: one-cycle event strobe on a falling edge.
// With BTN_AUTOREPEAT_EN defined, a held button also emits periodic repeat strobes.
module button_edge_detect #(
  parameter int unsigned REPEAT_CYCLES = 25000000,
  parameter int          REPEAT_W      = 25
) (
  input  logic CLOCK,
  input  logic Reset,
  input  logic i_btn,
  output logic o_event,
  output logic o_repeat
);

  logic r_prev_q;
  logic w_press;

  assign w_press = r_prev_q & ~i_btn;

  // prev_q resets to 0 so a button already held low at reset never looks like a press
  always_ff @(posedge CLOCK) begin
    if (Reset) r_prev_q <= 1'b0;
    else       r_prev_q <= i_btn;
  end

`ifdef BTN_AUTOREPEAT_EN
  logic [REPEAT_W-1:0] r_cnt;
  logic                w_wrap;

  assign w_wrap = ~i_btn & (r_cnt == REPEAT_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge CLOCK) begin
    if (Reset || i_btn || w_press) r_cnt <= '0;
    else if (w_wrap)               r_cnt <= '0;
    else                           r_cnt <= r_cnt + 1'b1;
  end

  assign o_event  = w_press | w_wrap;
  assign o_repeat = w_wrap & ~w_press;
`else
  logic w_unused_repeat;
  assign w_unused_repeat = ^(REPEAT_W'(REPEAT_CYCLES));
  assign o_event  = w_press;
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/button_event_arbiter.sv
// Press-event arbiter: pending/overrun flags per button, round-robin grant, valid/ready offer FSM.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_arbiter
  import button_event_pkg::*;
#(
  parameter int          NUM_BTN       = 4,
  parameter int          ID_W          = 2,
  parameter int unsigned REPEAT_CYCLES = 25000000,
  parameter int          REPEAT_W      = 25
) (
  input  logic                  CLOCK,
  input  logic                  Reset,
  input  logic [NUM_BTN-1:0]    ButtonIn,
  button_event_arbiter_if.master ev_if,
  output logic [NUM_BTN-1:0]    Overrun
);

  logic [NUM_BTN-1:0] w_event;
  logic [NUM_BTN-1:0] w_repeat;
  logic [NUM_BTN-1:0] w_clr;
  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] r_overrun;
  logic [0:0]         r_state;
  logic               r_valid;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_last;
  logic               w_hs;
  logic [MAX_BTN-1:0] w_req;
  logic [2:0]         w_pick;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_edge_detect #(
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_W     (REPEAT_W)
    ) u_edge (
      .CLOCK   (CLOCK),
      .Reset   (Reset),
      .i_btn   (ButtonIn[g]),
      .o_event (w_event[g]),
      .o_repeat(w_repeat[g])
    );
  end

  always_comb begin
    w_req = '0;
    w_req[NUM_BTN-1:0] = r_pending;
    w_pick = rr_pick(w_req, 3'(r_last), NUM_BTN);
  end

  assign w_hs  = (r_state == ST_OFFER) && ev_if.EventReady;
  assign w_clr = w_hs ? (NUM_BTN'(1) << r_id) : '0;

  // A new event on the button being cleared wins, so it is neither lost nor flagged as overrun.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_last    <= ID_W'(NUM_BTN - 1);
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_event;
      r_overrun <= r_overrun | (w_event & ~w_repeat & r_pending & ~w_clr);
      if (r_state == ST_IDLE) begin
        if (|r_pending) begin
          r_id    <= ID_W'(w_pick);
          r_valid <= 1'b1;
          r_state <= ST_OFFER;
        end
      end else if (w_hs) begin
        r_last  <= r_id;
        r_valid <= 1'b0;
        r_state <= ST_IDLE;
      end
    end
  end

  assign ev_if.EventValid = r_valid;
  assign ev_if.EventId    = r_id;
  assign Overrun          = r_overrun;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios plus random traffic against a cycle reference model.
// Defining BTN_AUTOREPEAT_EN also enables repeat modelling (repeat period 8 cycles).
module tb_button_event_arbiter;

  localparam int NB = 4;
  localparam int RC = 8;

  logic          clk;
  logic          Reset;
  logic [NB-1:0] ButtonIn;
  logic          EventReady;
  logic [NB-1:0] Overrun;

  button_event_arbiter_if #(.ID_W(2)) ev_if ();
  assign ev_if.EventReady = EventReady;

  button_event_arbiter #(
    .NUM_BTN(NB), .ID_W(2), .REPEAT_CYCLES(RC), .REPEAT_W(4)
  ) dut (
    .CLOCK   (clk),
    .Reset   (Reset),
    .ButtonIn(ButtonIn),
    .ev_if   (ev_if.master),
    .Overrun (Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int del_q[$];
  int del_cyc[$];

  // reference model state
  logic [NB-1:0] m_pend, m_ovr, m_prev;
  int            m_offered, m_last, m_id;
  int            held [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input logic [NB-1:0] btn, input logic rdy, input logic rst);
    int grant, pick;
    logic press, rep;
    logic [NB-1:0] new_ev;
    if (rst) begin
      m_pend = '0; m_ovr = '0; m_prev = '0;
      m_offered = -1; m_last = NB - 1; m_id = 0;
      for (int i = 0; i < NB; i++) held[i] = 0;
      return;
    end
    grant = (m_offered >= 0 && rdy) ? m_offered : -1;
    pick = -1;
    if (m_offered < 0)
      for (int k = 1; k <= NB; k++)
        if (pick < 0 && m_pend[(m_last + k) % NB]) pick = (m_last + k) % NB;
    new_ev = '0;
    for (int i = 0; i < NB; i++) begin
      press = m_prev[i] && !btn[i];
      rep = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      if (btn[i] || press) held[i] = 0;
      else begin
        held[i]++;
        if (held[i] == RC) begin held[i] = 0; rep = 1'b1; end
      end
`endif
      if (press && m_pend[i] && i != grant) m_ovr[i] = 1'b1;
      new_ev[i] = press | rep;
    end
    if (grant >= 0) begin
      m_pend[grant] = 1'b0; m_last = grant; m_offered = -1;
    end else if (pick >= 0) begin
      m_offered = pick; m_id = pick;
    end
    m_pend = m_pend | new_ev;
    m_prev = btn;
  endfunction

  task automatic cycle(input logic [NB-1:0] btn, input logic rdy, input logic rst);
    ButtonIn = btn; EventReady = rdy; Reset = rst;
    if (!rst && ev_if.EventValid === 1'b1 && rdy) begin
      del_q.push_back(int'(ev_if.EventId));
      del_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_step(btn, rdy, rst);
    cyc++;
    #1;
    chk("valid", 32'(ev_if.EventValid), 32'(m_offered >= 0));
    if (m_offered >= 0) chk("id", 32'(ev_if.EventId), 32'(m_id));
    chk("overrun", 32'(Overrun), 32'(m_ovr));
  endtask

  initial begin
    logic [NB-1:0] b;
    int cnt;
    Reset = 1'b1; ButtonIn = '1; EventReady = 1'b0;

    // 1: reset with toggling buttons, then button 0 held low across release
    for (int i = 0; i < 5; i++) cycle(NB'($urandom), 1'($urandom), 1'b1);
    chk("rst_valid", 32'(ev_if.EventValid), 32'd0);
    chk("rst_id", 32'(ev_if.EventId), 32'd0);
    chk("rst_overrun", 32'(Overrun), 32'd0);
    del_q.delete(); del_cyc.delete();
    for (int i = 0; i < 20; i++) cycle(4'b1110, 1'b1, 1'b0);
`ifndef BTN_AUTOREPEAT_EN
    chk("held_thru_reset_events", 32'(del_q.size()), 32'd0);
`endif

    // 2: single press of button 2
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 1'b0);
    del_q.delete(); del_cyc.delete();
    cycle(4'b1011, 1'b1, 1'b0);
    chk("press_pending_no_valid", 32'(ev_if.EventValid), 32'd0);
    cycle(4'b1011, 1'b1, 1'b0);
    chk("press_valid", 32'(ev_if.EventValid), 32'd1);
    chk("press_id", 32'(ev_if.EventId), 32'd2);
    cycle(4'b1011, 1'b1, 1'b0);
    chk("press_one_cycle", 32'(ev_if.EventValid), 32'd0);
    for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b1, 1'b0);
    chk("press_count", 32'(del_q.size()), 32'd1);

    // 3: grant id 1, then simultaneous press of 1 and 2
    del_q.delete(); del_cyc.delete();
    for (int i = 0; i < 4; i++) cycle(4'b1101, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(4'b1001, 1'b1, 1'b0);
    chk("rr_count", 32'(del_q.size()), 32'd3);
    if (del_q.size() == 3) begin
      chk("rr_first", 32'(del_q[1]), 32'd2);
      chk("rr_second", 32'(del_q[2]), 32'd1);
      chk("rr_spacing", 32'(del_cyc[2] - del_cyc[1]), 32'd2);
    end
    for (int i = 0; i < 2; i++) cycle(4'b1111, 1'b1, 1'b0);

    // 4: coalesced re-press while stalled
    del_q.delete(); del_cyc.delete();
    cycle(4'b1101, 1'b0, 1'b0);
    cycle(4'b1101, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1101, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b1101, 1'b0, 1'b0);
    chk("stall_valid", 32'(ev_if.EventValid), 32'd1);
    chk("stall_id", 32'(ev_if.EventId), 32'd1);
    chk("stall_overrun", 32'(Overrun), 32'b0010);
    for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b1, 1'b0);
    chk("coalesced_count", 32'(del_q.size()), 32'd1);

    // 5: reset while offering id 3
    for (int i = 0; i < 3; i++) cycle(4'b0111, 1'b0, 1'b0);
    chk("pre_rst_id", 32'(ev_if.EventId), 32'd3);
    cycle(4'b0111, 1'b0, 1'b1);
    chk("mid_rst_valid", 32'(ev_if.EventValid), 32'd0);
    chk("mid_rst_overrun", 32'(Overrun), 32'd0);
    del_q.delete(); del_cyc.delete();
    for (int i = 0; i < 2; i++) cycle(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(4'b1110, 1'b1, 1'b0);
    chk("post_rst_count", 32'(del_q.size()), 32'd1);
    if (del_q.size() >= 1) chk("post_rst_first", 32'(del_q[0]), 32'd0);

    // 6: long hold of button 0
    for (int i = 0; i < 2; i++) cycle(4'b1111, 1'b1, 1'b0);
    del_q.delete(); del_cyc.delete();
    for (int i = 0; i < 30; i++) cycle(4'b1110, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 1'b0);
    cnt = 0;
    foreach (del_q[j]) if (del_q[j] == 0) cnt++;
`ifdef BTN_AUTOREPEAT_EN
    chk("hold_events", 32'(cnt), 32'd4);
`else
    chk("hold_events", 32'(cnt), 32'd1);
`endif
    chk("hold_overrun", 32'(Overrun[0]), 32'd0);

    // random traffic
    b = '1;
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < NB; j++)
        if ($urandom_range(0, 3) == 0) b[j] = ~b[j];
      cycle(b, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 79) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
